// File: rtl/scratchpad_responder.sv
// scratchpad_responder
//   Multi-port word scratchpad serving the systolic array request interface.
//   Every cycle it services N lane read requests (X and W address per lane),
//   N lane writes and one controller read/write. Read data is registered, so
//   it appears one cycle after the request. After reset a clear sequencer
//   zeroes every word, and then sc_ready rises.
//
//   Optional build macro: SCRATCHPAD_PARITY_EN adds an even-parity bit per
//   word and a sticky parity_err output.
//
// Ports
//   clk, n_rst              clock; asynchronous active-low reset
//   sc_x_queue/sc_w_queue   per-lane X/W read word address
//   sc_valid_queue          per-lane read valid
//   sc_valid_write          per-lane write valid
//   sc_write_queue/_data    per-lane write address/data
//   sc_x_data/sc_w_data     registered per-lane read data
//   controller_sc_*         host load/unload port (strobes, address, data)
//   sc_ready                clear finished, array accessible
//   addr_err                sticky out-of-range access flag
//   parity_err              sticky parity mismatch flag (parity build only)
module scratchpad_responder #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [N-1:0][31:0]             sc_x_queue,
    input  logic [N-1:0][31:0]             sc_w_queue,
    input  logic [N-1:0]                   sc_valid_queue,
    input  logic [N-1:0]                   sc_valid_write,
    input  logic [N-1:0][31:0]             sc_write_queue,
    input  logic [N-1:0][DATA_WIDTH-1:0]   sc_write_data,
    output logic [N-1:0][DATA_WIDTH-1:0]   sc_x_data,
    output logic [N-1:0][DATA_WIDTH-1:0]   sc_w_data,
    input  logic                           controller_sc_read_en,
    input  logic                           controller_sc_write_en,
    input  logic [31:0]                    controller_sc_addr,
    input  logic [DATA_WIDTH-1:0]          controller_sc_in,
    output logic [DATA_WIDTH-1:0]          controller_sc_out,
    output logic                           sc_ready,
    output logic                           addr_err
`ifdef SCRATCHPAD_PARITY_EN
    ,
    output logic                           parity_err
`endif
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                         state_q, state_d;
    logic [AW-1:0]                  clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]          mem [DEPTH];

    logic [N-1:0][DATA_WIDTH-1:0]   sc_x_q, sc_x_d;
    logic [N-1:0][DATA_WIDTH-1:0]   sc_w_q, sc_w_d;
    logic [DATA_WIDTH-1:0]          ctl_out_q, ctl_out_d;
    logic                           addr_err_q, addr_err_d;

    logic                           rdy;
    logic [N-1:0]                   x_ok, w_ok, wr_ok, lane_rd, lane_wr;
    logic                           ctl_ok, ctl_hit, ctl_wr, ctl_rd, oor_any;

    assign rdy = (state_q == S_READY);

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) state_d = S_READY;
            end
            default: state_d = S_READY;
        endcase
    end

    // ---------------- request decode ----------------
    always_comb begin
        x_ok    = '0;
        w_ok    = '0;
        wr_ok   = '0;
        lane_rd = '0;
        lane_wr = '0;
        ctl_hit = 1'b0;
        oor_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            x_ok[i]    = sc_x_queue[i] < DEPTH_W;
            w_ok[i]    = sc_w_queue[i] < DEPTH_W;
            wr_ok[i]   = sc_write_queue[i] < DEPTH_W;
            lane_rd[i] = rdy & sc_valid_queue[i];
            lane_wr[i] = rdy & sc_valid_write[i] & wr_ok[i];
            // Lane writes own an address outright; a controller write to it is lost.
            if (lane_wr[i] && sc_write_queue[i] == controller_sc_addr) ctl_hit = 1'b1;
            if (lane_rd[i] && !(x_ok[i] && w_ok[i])) oor_any = 1'b1;
            if (rdy && sc_valid_write[i] && !wr_ok[i]) oor_any = 1'b1;
        end
        ctl_ok = controller_sc_addr < DEPTH_W;
        ctl_wr = rdy & controller_sc_write_en & ctl_ok & ~ctl_hit;
        ctl_rd = rdy & controller_sc_read_en & ctl_ok;
        if (rdy && (controller_sc_read_en || controller_sc_write_en) && !ctl_ok) oor_any = 1'b1;
    end

    // ---------------- read data (sampled before this edge's writes) ----------------
    always_comb begin
        sc_x_d = '0;
        sc_w_d = '0;
        for (int i = 0; i < N; i++) begin
            if (lane_rd[i] && x_ok[i]) sc_x_d[i] = mem[sc_x_queue[i][AW-1:0]];
            if (lane_rd[i] && w_ok[i]) sc_w_d[i] = mem[sc_w_queue[i][AW-1:0]];
        end
        ctl_out_d = ctl_out_q;
        if (ctl_rd)
            ctl_out_d = mem[controller_sc_addr[AW-1:0]];
        else if (rdy && controller_sc_read_en)
            ctl_out_d = '0;
        addr_err_d = addr_err_q | oor_any;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sc_x_q     <= '0;
            sc_w_q     <= '0;
            ctl_out_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            sc_x_q     <= sc_x_d;
            sc_w_q     <= sc_w_d;
            ctl_out_q  <= ctl_out_d;
            addr_err_q <= addr_err_d;
        end
    end

    // ---------------- storage ----------------
    // Later assignments win, so the ascending lane loop gives the highest lane
    // priority on a shared address.
    always_ff @(posedge clk) begin
        if (!rdy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (ctl_wr) mem[controller_sc_addr[AW-1:0]] <= controller_sc_in;
            for (int i = 0; i < N; i++)
                if (lane_wr[i]) mem[sc_write_queue[i][AW-1:0]] <= sc_write_data[i];
        end
    end

`ifdef SCRATCHPAD_PARITY_EN
    logic mem_par [DEPTH];
    logic par_bad;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (!rdy) begin
            mem_par[clr_cnt_q] <= 1'b0;
        end else begin
            if (ctl_wr) mem_par[controller_sc_addr[AW-1:0]] <= ^controller_sc_in;
            for (int i = 0; i < N; i++)
                if (lane_wr[i]) mem_par[sc_write_queue[i][AW-1:0]] <= ^sc_write_data[i];
        end
    end

    // Recompute parity on every word that is being delivered this edge.
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lane_rd[i] && x_ok[i] &&
                ((^mem[sc_x_queue[i][AW-1:0]]) != mem_par[sc_x_queue[i][AW-1:0]])) par_bad = 1'b1;
            if (lane_rd[i] && w_ok[i] &&
                ((^mem[sc_w_queue[i][AW-1:0]]) != mem_par[sc_w_queue[i][AW-1:0]])) par_bad = 1'b1;
        end
        if (ctl_rd && ((^mem[controller_sc_addr[AW-1:0]]) != mem_par[controller_sc_addr[AW-1:0]]))
            par_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_q | par_bad;
    end

    assign parity_err = parity_err_q;
`endif

    assign sc_x_data         = sc_x_q;
    assign sc_w_data         = sc_w_q;
    assign controller_sc_out = ctl_out_q;
    assign sc_ready          = rdy;
    assign addr_err          = addr_err_q;

endmodule
